// File: rtl/vend_pkg.sv
// Shared codes, FSM state encoding and code sanitising helper for the
// vending-core arbiter.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_10   = 2'b01;
    localparam logic [1:0] COIN_50   = 2'b10;
    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_20    = 2'b01;
    localparam logic [1:0] SEL_50    = 2'b10;
    localparam logic [1:0] CODE_BAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COIN0 = 3'd1,
        ST_GAP0  = 3'd2,
        ST_COIN1 = 3'd3,
        ST_GAP1  = 3'd4,
        ST_SEL   = 3'd5,
        ST_WAIT  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    // The unused 2'b11 code collapses to "none" so the core never sees it.
    function automatic logic [1:0] legal_code(input logic [1:0] code);
        legal_code = (code == CODE_BAD) ? 2'b00 : code;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic [PW-1:0]    o_idx,
    output logic             o_valid
);

    int w_pos;

    // Scan outward from the pointer, wrapping, and keep the first hit.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = (int'(i_ptr) + k) % N_REQ;
            if (!o_valid && i_req[w_pos]) begin
                o_pick[w_pos] = 1'b1;
                o_idx         = PW'(w_pos);
                o_valid       = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/vend_arbiter.sv
// Round-robin sharing of one vending core between several front panels:
// replays the granted panel's coins/selection as spaced pulses, returns the result.
module vend_arbiter
    import vend_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   coin0_in,
    input  logic [2*N_REQ-1:0]   coin1_in,
    input  logic [2*N_REQ-1:0]   sel_in,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic [1:0]           item_out,
    output logic [1:0]           change_out,
    output logic [1:0]           core_money,
    output logic [1:0]           core_select,
    input  logic [1:0]           core_item,
    input  logic [1:0]           core_change
);

    localparam int PW   = $clog2(N_REQ);
    localparam int CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    state_e           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_gidx;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_err;
    logic [1:0]       r_item;
    logic [1:0]       r_change;
    logic [1:0]       r_money;
    logic [1:0]       r_select;
    logic [1:0]       r_coin0;
    logic [1:0]       r_coin1;
    logic [1:0]       r_sel;
    logic [CW-1:0]    r_cnt;

    logic [N_REQ-1:0] w_pick;
    logic [PW-1:0]    w_idx;
    logic             w_valid;
    logic [1:0]       w_coin0;
    logic [1:0]       w_coin1;
    logic [1:0]       w_sel;
    logic             w_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_coin0 = coin0_in[{w_idx, 1'b0} +: 2];
    assign w_coin1 = coin1_in[{w_idx, 1'b0} +: 2];
    assign w_sel   = sel_in[{w_idx, 1'b0} +: 2];
    assign w_hit   = ((core_item | core_change) != 2'b00);

    assign grant       = r_grant;
    assign done        = r_done;
    assign err         = r_err;
    assign item_out    = r_item;
    assign change_out  = r_change;
    assign core_money  = r_money;
    assign core_select = r_select;

    // Transaction sequencer; core pulses and done/err default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_item   <= 2'b00;
            r_change <= 2'b00;
            r_money  <= 2'b00;
            r_select <= 2'b00;
            r_coin0  <= 2'b00;
            r_coin1  <= 2'b00;
            r_sel    <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_money  <= COIN_NONE;
            r_select <= SEL_NONE;
            r_done   <= '0;
            r_err    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_idx;
                        r_coin0 <= legal_code(w_coin0);
                        r_coin1 <= legal_code(w_coin1);
                        r_sel   <= legal_code(w_sel);
                        r_cnt   <= '0;
                        r_state <= ST_COIN0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COIN0: begin
                    r_money <= r_coin0;
                    r_cnt   <= '0;
                    r_state <= ST_GAP0;
                end
                ST_GAP0: begin
                    if (r_cnt == CW'(GAP - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_COIN1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_COIN1: begin
                    r_cnt <= '0;
                    if (r_coin1 != COIN_NONE) begin
                        r_money <= r_coin1;
                        r_state <= ST_GAP1;
                    end else begin
                        r_state <= ST_SEL;
                    end
                end
                ST_GAP1: begin
                    if (r_cnt == CW'(GAP - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_SEL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SEL: begin
                    r_select <= r_sel;
                    r_cnt    <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done/err is raised on entry so it coincides with the DONE cycle.
                    if (w_hit) begin
                        r_item   <= core_item;
                        r_change <= core_change;
                        r_done   <= r_grant;
                        r_cnt    <= '0;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= r_grant;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= (r_gidx == PW'(N_REQ - 1)) ? '0 : (r_gidx + 1'b1);
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_arbiter.sv
// Self-checking bench for vend_arbiter with a reactive core model and a
// schedule-based reference for pulses, results and round-robin order.
module tb_vend_arbiter;

    localparam int N_REQ    = 2;
    localparam int GAP      = 2;
    localparam int TIMEOUT  = 16;
    localparam int RESP_DLY = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_REQ-1:0]    req = '0;
    logic [2*N_REQ-1:0]  coin0_in = '0;
    logic [2*N_REQ-1:0]  coin1_in = '0;
    logic [2*N_REQ-1:0]  sel_in = '0;
    logic [N_REQ-1:0]    grant, done, err;
    logic [1:0]          item_out, change_out, core_money, core_select;
    logic [1:0]          core_item = 2'b00;
    logic [1:0]          core_change = 2'b00;

    int       checks = 0;
    int       errors = 0;
    int       tb_ptr = 0;
    logic [1:0] exp_item = 2'b00;
    logic [1:0] exp_chg = 2'b00;

    bit       core_silent = 1'b0;
    bit       core_armed = 1'b0;
    int       core_cd = 0;
    logic [1:0] resp_item = 2'b01;
    logic [1:0] resp_chg = 2'b00;

    always #5 clk = ~clk;

    vend_arbiter #(.N_REQ(N_REQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .coin0_in(coin0_in), .coin1_in(coin1_in), .sel_in(sel_in),
        .grant(grant), .done(done), .err(err),
        .item_out(item_out), .change_out(change_out),
        .core_money(core_money), .core_select(core_select),
        .core_item(core_item), .core_change(core_change)
    );

    // Core model: answers RESP_DLY cycles after the latest pulse, holds the answer
    // until the next pulse, and forgets everything while nobody is granted.
    always @(negedge clk) begin
        if (!rst_n || grant == '0) begin
            core_armed  = 1'b0;
            core_cd     = 0;
            core_item   = 2'b00;
            core_change = 2'b00;
        end else if (core_money != 2'b00 || core_select != 2'b00) begin
            core_item   = 2'b00;
            core_change = 2'b00;
            core_armed  = 1'b1;
            core_cd     = RESP_DLY;
        end else if (core_armed) begin
            core_cd = core_cd - 1;
            if (core_cd == 0) begin
                core_armed = 1'b0;
                if (!core_silent) begin
                    core_item   = resp_item;
                    core_change = resp_chg;
                end
            end
        end
    end

    function automatic logic [1:0] san(input logic [1:0] c);
        return (c == 2'b11) ? 2'b00 : c;
    endfunction

    // One full transaction: offsets are cycles after grant is first seen.
    task automatic do_txn(input logic [N_REQ-1:0] reqv, input logic [2*N_REQ-1:0] c0,
                          input logic [2*N_REQ-1:0] c1, input logic [2*N_REQ-1:0] s,
                          input bit silent, input bit drop, input string tag);
        int g, tc1, ts, last, h, e;
        bit ok;
        logic [N_REQ-1:0] oh;
        logic [1:0] c0e, c1e, se, em, es;
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (g < 0 && reqv[(tb_ptr + k) % N_REQ]) g = (tb_ptr + k) % N_REQ;
        end
        if (g < 0) g = 0;
        oh = '0;
        oh[g] = 1'b1;
        c0e = san(c0[2*g +: 2]);
        c1e = san(c1[2*g +: 2]);
        se  = san(s[2*g +: 2]);
        do begin
            resp_item = 2'($urandom_range(0, 3));
            resp_chg  = 2'($urandom_range(0, 3));
        end while ((resp_item | resp_chg) == 2'b00);
        core_silent = silent;
        req = reqv; coin0_in = c0; coin1_in = c1; sel_in = s;

        tc1  = GAP + 2;
        ts   = (c1e != 2'b00) ? (2*GAP + 3) : (GAP + 3);
        last = -1;
        if (c0e != 2'b00) last = 1;
        if (c1e != 2'b00) last = tc1;
        if (se != 2'b00)  last = ts;
        ok = !silent && (last >= 0);
        if (ok) begin
            h = (ts > last + RESP_DLY) ? ts : (last + RESP_DLY);
            e = h + 1;
        end else begin
            e = ts + TIMEOUT;
        end

        @(negedge clk);
        checks++;
        if (grant !== oh) begin
            $display("FAIL %s grant: got %b want %b", tag, grant, oh);
            errors++;
        end
        coin0_in = 4'($urandom); coin1_in = 4'($urandom); sel_in = 4'($urandom);
        if (drop) req[g] = 1'b0;

        for (int t = 1; t <= e; t++) begin
            @(negedge clk);
            em = (t == 1) ? c0e : ((c1e != 2'b00 && t == tc1) ? c1e : 2'b00);
            es = (se != 2'b00 && t == ts) ? se : 2'b00;
            checks++;
            if ({core_money, core_select} !== {em, es}) begin
                $display("FAIL %s core_bus t=%0d: got money %b sel %b want money %b sel %b",
                         tag, t, core_money, core_select, em, es);
                errors++;
            end
            checks++;
            if ({grant, done, err} !== {oh, (ok && t == e) ? oh : '0, (!ok && t == e) ? oh : '0}) begin
                $display("FAIL %s ctrl t=%0d: got grant %b done %b err %b want ok=%0d end=%0d",
                         tag, t, grant, done, err, ok, e);
                errors++;
            end
        end
        if (ok) begin
            exp_item = resp_item;
            exp_chg  = resp_chg;
        end
        @(negedge clk);
        checks++;
        if ({grant, item_out, change_out} !== {{N_REQ{1'b0}}, exp_item, exp_chg}) begin
            $display("FAIL %s result: got grant %b item %b change %b want grant 0 item %b change %b",
                     tag, grant, item_out, change_out, exp_item, exp_chg);
            errors++;
        end
        tb_ptr = (g + 1) % N_REQ;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, done, err, item_out, change_out, core_money, core_select} !== '0) begin
            $display("FAIL reset_outputs: got %b want 0",
                     {grant, done, err, item_out, change_out, core_money, core_select});
            errors++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== '0) begin
            $display("FAIL idle_no_req: got grant %b want 0", grant);
            errors++;
        end
    endtask

    task automatic test_single();
        do_txn(2'b01, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "single");
    endtask

    task automatic test_skip_coin1();
        do_txn(2'b10, 4'b1000, 4'b0000, 4'b0100, 1'b0, 1'b0, "skip_coin1");
    endtask

    task automatic test_back_to_back();
        do_txn(2'b11, 4'b0110, 4'b1001, 4'b1001, 1'b0, 1'b0, "b2b_first");
        do_txn(2'b11, 4'b0110, 4'b1001, 4'b1001, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_timeout();
        do_txn(2'b01, 4'b0001, 4'b0000, 4'b0010, 1'b1, 1'b0, "timeout");
    endtask

    task automatic test_illegal_drop();
        do_txn(2'b10, 4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b1, "illegal_drop");
        do_txn(2'b01, 4'b0011, 4'b0000, 4'b0011, 1'b0, 1'b1, "all_illegal");
    endtask

    task automatic test_reset_mid();
        bit quiet;
        do_txn(2'b01, 4'b0010, 4'b0000, 4'b0001, 1'b0, 1'b0, "pre_reset");
        req = 2'b01; coin0_in = 4'b0001; coin1_in = 4'b0001; sel_in = 4'b0001;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({grant, done, err, core_money, core_select, item_out, change_out} !== '0) begin
            $display("FAIL reset_mid: got %b want 0",
                     {grant, done, err, core_money, core_select, item_out, change_out});
            errors++;
        end
        quiet = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if ((done | err) != '0 || core_money != 2'b00) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            $display("FAIL reset_abort_quiet: got activity after reset want none");
            errors++;
        end
        tb_ptr = 0; exp_item = 2'b00; exp_chg = 2'b00;
        do_txn(2'b11, 4'b0101, 4'b0000, 4'b0110, 1'b0, 1'b0, "post_reset_ptr");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                   ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "random");
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_skip_coin1();
        test_back_to_back();
        test_timeout();
        test_illegal_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
